// File: rtl/hex_digit_scanner.sv
// hex_digit_scanner: six-digit time-multiplexed hex display driver.
// A free-running prescaler and digit counter scan the bank. The input word is
// snapshotted once per frame, so every frame shows one coherent value.
// All outputs are registered one cycle behind the internal counters.
module hex_digit_scanner #(
    parameter int unsigned DIV        = 4096,
    parameter int unsigned BLANK      = 256,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] A,
    input  logic        lz_en,
    output logic [6:0]  seg,
    output logic [5:0]  an,
    output logic [2:0]  sel,
    output logic        frame_done
);

    localparam int unsigned   CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [6:0]    SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [5:0]    AN_OFF  = ACTIVE_LOW ? 6'h3F : 6'h00;

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } slot_state_e;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h3F;
            4'h1:    pat = 7'h06;
            4'h2:    pat = 7'h5B;
            4'h3:    pat = 7'h4F;
            4'h4:    pat = 7'h66;
            4'h5:    pat = 7'h6D;
            4'h6:    pat = 7'h7D;
            4'h7:    pat = 7'h07;
            4'h8:    pat = 7'h7F;
            4'h9:    pat = 7'h6F;
            4'hA:    pat = 7'h77;
            4'hB:    pat = 7'h7C;
            4'hC:    pat = 7'h39;
            4'hD:    pat = 7'h5E;
            4'hE:    pat = 7'h79;
            default: pat = 7'h71;
        endcase
        return pat;
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    dig_q, dig_d;
    logic [23:0]   snap_q, snap_d;
    slot_state_e   state_q, state_d;

    logic [6:0]    seg_q, seg_d;
    logic [5:0]    an_q, an_d;
    logic [2:0]    sel_q, sel_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_wrap;
    logic [23:0]   snap_shifted;
    logic          lead_blank;

    // Prescaler, digit counter and frame snapshot next-state.
    always_comb begin
        slot_wrap = (cnt_q == CNT_MAX);
        cnt_d     = slot_wrap ? '0 : cnt_q + 1'b1;
        dig_d     = dig_q;
        if (slot_wrap) begin
            dig_d = (dig_q == 3'd5) ? 3'd0 : dig_q + 3'd1;
        end
        // snap_d is also the word being displayed this cycle, so digit 0 of a
        // new frame already uses the freshly captured value when BLANK is 0.
        snap_d = ((cnt_q == '0) && (dig_q == 3'd0)) ? A : snap_q;
    end

    // Slot FSM next state and registered-output next values.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = (32'(cnt_d) < BLANK) ? ST_BLANK : ST_SHOW;
        seg_d        = SEG_OFF;
        an_d         = AN_OFF;
        sel_d        = dig_q;
        frame_done_d = (dig_q == 3'd5) && slot_wrap;

        // Digit is suppressed when it and every more significant nibble is 0;
        // digit 0 is never suppressed, so a zero word still shows "0".
        snap_shifted = snap_d >> {dig_q, 2'b00};
        lead_blank   = lz_en && (dig_q != 3'd0) && (snap_shifted == 24'd0);

        if ((state_q == ST_SHOW) && !lead_blank) begin
            seg_d = hex_decode(snap_shifted[3:0]) ^ SEG_OFF;
            an_d  = (6'd1 << dig_q) ^ AN_OFF;
        end
    end

    // Scan counters, snapshot and slot state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            cnt_q   <= '0;
            dig_q   <= 3'd0;
            // NOTE: the snapshot is an ordinary 24-bit register, not a memory,
            // so clearing it in reset costs nothing and keeps it well defined.
            snap_q  <= 24'd0;
            state_q <= (BLANK == 0) ? ST_SHOW : ST_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            snap_q  <= snap_d;
            state_q <= state_d;
        end
    end

    // Output registers; reset forces the off levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            sel_q        <= 3'd0;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            sel_q        <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;

endmodule
